// File: rtl/nb_tx_pkg.sv
// Shared types and slot geometry for the NB-IoT transmit resource mapper.
package nb_tx_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int N_SC       = 12;
    localparam int N_SYM      = 7;
    localparam int PILOT_SYM  = 3;

    typedef enum logic [2:0] {
        IDLE,
        MAP,
        PILOT,
        DRAIN,
        DONE
    } map_state_t;

    typedef logic signed [2*DATA_WIDTH-1:0] cplx_t;

endpackage

// File: rtl/tx_pilot_mapper_ctrl.sv
// Slot sequencer for the pilot mapper: state, subcarrier/symbol counters and
// the load/ready decode that steers the output register in the top level.
module map_ctrl_fsm #(
    parameter int N_SC      = nb_tx_pkg::N_SC,
    parameter int N_SYM     = nb_tx_pkg::N_SYM,
    parameter int PILOT_SYM = nb_tx_pkg::PILOT_SYM
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       data_valid_i,
    input  logic       out_valid_i,
    input  logic       out_ready_i,
    output logic       load_en_o,
    output logic       data_ready_o,
    output logic       load_o,
    output logic       pilot_sel_o,
    output logic       start_acc_o,
    output logic       slot_done_o,
    output logic [3:0] sc_o,
    output logic [2:0] sym_o
);
    import nb_tx_pkg::*;

    map_state_t state_q, state_d;
    logic [3:0] sc_q, sc_d;
    logic [2:0] sym_q, sym_d;
    logic       last_re;

    // The output register may take a new RE when empty or being drained this cycle.
    assign load_en_o = !out_valid_i || out_ready_i;
    assign last_re   = (sym_q == 3'(N_SYM - 1)) && (sc_q == 4'(N_SC - 1));
    assign sc_o      = sc_q;
    assign sym_o     = sym_q;

    // Next-state, counter advance and load/ready decode.
    always_comb begin
        state_d      = state_q;
        sc_d         = sc_q;
        sym_d        = sym_q;
        data_ready_o = 1'b0;
        load_o       = 1'b0;
        pilot_sel_o  = 1'b0;
        start_acc_o  = 1'b0;
        slot_done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    start_acc_o = 1'b1;
                    sc_d        = '0;
                    sym_d       = '0;
                    state_d     = (PILOT_SYM == 0) ? PILOT : MAP;
                end
            end
            MAP: begin
                data_ready_o = load_en_o;
                load_o       = load_en_o && data_valid_i;
            end
            PILOT: begin
                load_o      = load_en_o;
                pilot_sel_o = 1'b1;
            end
            DRAIN: begin
                if (out_valid_i && out_ready_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                slot_done_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Every loaded RE advances the grid position; the symbol about to be
        // filled decides whether the next REs come from input or the pilot table.
        if (load_o) begin
            if (sc_q == 4'(N_SC - 1)) begin
                sc_d  = '0;
                sym_d = sym_q + 3'd1;
            end else begin
                sc_d = sc_q + 4'd1;
            end
            if (last_re) begin
                state_d = DRAIN;
            end else if (sym_d == 3'(PILOT_SYM)) begin
                state_d = PILOT;
            end else begin
                state_d = MAP;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sc_q    <= '0;
            sym_q   <= '0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            sym_q   <= sym_d;
        end
    end

endmodule

// File: rtl/tx_pilot_mapper.sv
// NPUSCH resource mapper: interleaves 72 data REs with a 12-RE DMRS symbol
// into an 84-RE slot, subcarrier-major within each symbol.
module tx_pilot_mapper #(
    parameter int DATA_WIDTH = nb_tx_pkg::DATA_WIDTH,
    parameter int N_SC       = nb_tx_pkg::N_SC,
    parameter int N_SYM      = nb_tx_pkg::N_SYM,
    parameter int PILOT_SYM  = nb_tx_pkg::PILOT_SYM
) (
    input  logic                                 i_clk_map,
    input  logic                                 i_rst_n,
    input  logic                                 i_start,
    input  logic [N_SC-1:0][2*DATA_WIDTH-1:0]    i_pilot,
    input  logic                                 i_data_valid,
    input  logic [2*DATA_WIDTH-1:0]              i_data,
    output logic                                 o_data_ready,
    output logic                                 o_valid,
    input  logic                                 i_out_ready,
    output logic [2*DATA_WIDTH-1:0]              o_re,
    output logic [3:0]                           o_sc_idx,
    output logic [2:0]                           o_sym_num,
    output logic                                 o_pilot_flag,
    output logic                                 o_slot_done
);
    import nb_tx_pkg::*;

    logic [N_SC-1:0][2*DATA_WIDTH-1:0] pilot_q;
    logic       load_en;
    logic       load;
    logic       pilot_sel;
    logic       start_acc;
    logic [3:0] sc;
    logic [2:0] sym;

    map_ctrl_fsm #(
        .N_SC      (N_SC),
        .N_SYM     (N_SYM),
        .PILOT_SYM (PILOT_SYM)
    ) u_ctrl (
        .clk_i        (i_clk_map),
        .rst_ni       (i_rst_n),
        .start_i      (i_start),
        .data_valid_i (i_data_valid),
        .out_valid_i  (o_valid),
        .out_ready_i  (i_out_ready),
        .load_en_o    (load_en),
        .data_ready_o (o_data_ready),
        .load_o       (load),
        .pilot_sel_o  (pilot_sel),
        .start_acc_o  (start_acc),
        .slot_done_o  (o_slot_done),
        .sc_o         (sc),
        .sym_o        (sym)
    );

    // Snapshot the DMRS vector at slot start so later input changes cannot leak in.
    always_ff @(posedge i_clk_map or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pilot_q <= '0;
        end else if (start_acc) begin
            pilot_q <= i_pilot;
        end
    end

    // Single output register; held unchanged while downstream stalls.
    always_ff @(posedge i_clk_map or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid      <= 1'b0;
            o_re         <= '0;
            o_sc_idx     <= '0;
            o_sym_num    <= '0;
            o_pilot_flag <= 1'b0;
        end else if (load_en) begin
            o_valid      <= load;
            o_pilot_flag <= load && pilot_sel;
            if (load) begin
                o_re      <= pilot_sel ? pilot_q[sc] : i_data;
                o_sc_idx  <= sc;
                o_sym_num <= sym;
            end
        end
    end

endmodule

// File: tb/tb_tx_pilot_mapper.sv
// Directed bench for tx_pilot_mapper: default geometry plus a PILOT_SYM=0 instance.
module tb_tx_pilot_mapper;
    import nb_tx_pkg::*;

    localparam int NOUT = 84;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic              start, dvalid, out_ready;
    logic [11:0][31:0] pilot;
    logic [31:0]       data;
    logic              data_ready, valid, pflag, sdone;
    logic [31:0]       re;
    logic [3:0]        sc;
    logic [2:0]        sym;

    logic              start1, dvalid1, out_ready1;
    logic [11:0][31:0] pilot1;
    logic [31:0]       data1;
    logic              data_ready1, valid1, pflag1, sdone1;
    logic [31:0]       re1;
    logic [3:0]        sc1;
    logic [2:0]        sym1;

    int n_cmp, n_bad;

    logic [39:0] got_w   [NOUT];
    int          got_cyc [NOUT];
    int got_cnt, stall_err, rdy_err, done_cnt, done_gap, timeout;

    tx_pilot_mapper dut (
        .i_clk_map(clk), .i_rst_n(rst_n), .i_start(start), .i_pilot(pilot),
        .i_data_valid(dvalid), .i_data(data), .o_data_ready(data_ready),
        .o_valid(valid), .i_out_ready(out_ready), .o_re(re), .o_sc_idx(sc),
        .o_sym_num(sym), .o_pilot_flag(pflag), .o_slot_done(sdone)
    );

    tx_pilot_mapper #(.PILOT_SYM(0)) dut1 (
        .i_clk_map(clk), .i_rst_n(rst_n), .i_start(start1), .i_pilot(pilot1),
        .i_data_valid(dvalid1), .i_data(data1), .o_data_ready(data_ready1),
        .o_valid(valid1), .i_out_ready(out_ready1), .o_re(re1), .o_sc_idx(sc1),
        .o_sym_num(sym1), .o_pilot_flag(pflag1), .o_slot_done(sdone1)
    );

    function automatic cplx_t pilot_val(input int k, input int base);
        return {16'(k + base), 16'(k)};
    endfunction

    function automatic logic [31:0] data_val(input int n);
        return {16'(n), 16'(-n)};
    endfunction

    function automatic logic [11:0][31:0] pilot_vec(input int base);
        logic [11:0][31:0] v;
        for (int k = 0; k < 12; k++) v[k] = pilot_val(k, base);
        return v;
    endfunction

    // Expected {re, sc, sym, flag} of the k-th output RE for a given pilot symbol.
    function automatic logic [39:0] exp_word(input int k, input int ps);
        int s, y, n;
        logic [31:0] v;
        logic f;
        y = k / 12;
        s = k % 12;
        if (y == ps) begin
            v = {16'(s + 'h100), 16'(s)};
            f = 1'b1;
        end else begin
            n = ((y > ps) ? y - 1 : y) * 12 + s;
            v = {16'(n), 16'(-n)};
            f = 1'b0;
        end
        return {v, 4'(s), 3'(y), f};
    endfunction

    // Drives one slot on dut and records every output handshake.
    task automatic run_slot(input int rmode, input int sparse, input int inject_at, input int stop_at);
        int in_idx, hs_cyc;
        logic hold;
        logic [39:0] h_w;
        bit injected;
        got_cnt = 0; stall_err = 0; rdy_err = 0; done_cnt = 0; done_gap = -1; timeout = 0;
        in_idx = 0; hs_cyc = -100; hold = 1'b0; h_w = '0; injected = 1'b0;
        pilot = pilot_vec('h100);
        dvalid = 1'b0; out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            out_ready = (rmode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
            dvalid = (in_idx < 72) && (sparse == 0 || (cyc % 3) == 0);
            data = data_val(in_idx);
            start = 1'b0;
            if (inject_at >= 0 && !injected && got_cnt >= inject_at) begin
                start = 1'b1;
                pilot = pilot_vec('h200);
                injected = 1'b1;
            end
            @(negedge clk);
            if (hold && ({re, sc, sym, pflag} !== h_w || valid !== 1'b1)) stall_err++;
            if (valid && !out_ready && data_ready) rdy_err++;
            if (sdone) begin
                done_cnt++;
                done_gap = cyc - hs_cyc;
            end
            hold = valid && !out_ready;
            h_w = {re, sc, sym, pflag};
            if (valid && out_ready) begin
                if (got_cnt < NOUT) begin
                    got_w[got_cnt] = {re, sc, sym, pflag};
                    got_cyc[got_cnt] = cyc;
                end
                got_cnt++;
                if (got_cnt == NOUT) hs_cyc = cyc;
            end
            if (dvalid && data_ready) in_idx++;
            if (stop_at >= 0 && got_cnt >= stop_at) return;
            @(posedge clk); #1;
            if (got_cnt >= NOUT && cyc > hs_cyc + 3) return;
        end
        timeout = 1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid); end
        n_cmp++; if (re !== 32'h0) begin n_bad++; $display("FAIL reset_re got %h want 0", re); end
        n_cmp++; if ({sc, sym} !== 7'h0) begin n_bad++; $display("FAIL reset_idx got %h/%h want 0/0", sc, sym); end
        n_cmp++; if ({pflag, sdone, data_ready} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {pflag, sdone, data_ready}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        run_slot(0, 0, -1, -1);
        n_cmp++; if (timeout !== 0) begin n_bad++; $display("FAIL basic_timeout got %0d want 0", timeout); end
        n_cmp++; if (got_cnt !== NOUT) begin n_bad++; $display("FAIL basic_count got %0d want %0d", got_cnt, NOUT); end
        for (int k = 0; k < NOUT; k++) begin
            n_cmp++;
            if (got_w[k] !== exp_word(k, 3)) begin n_bad++; $display("FAIL basic_re[%0d] got %h want %h", k, got_w[k], exp_word(k, 3)); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
        n_cmp++; if (done_gap !== 1) begin n_bad++; $display("FAIL basic_done_gap got %0d want 1", done_gap); end
    endtask

    task automatic test_backpressure;
        run_slot(1, 0, -1, -1);
        n_cmp++; if (got_cnt !== NOUT) begin n_bad++; $display("FAIL bp_count got %0d want %0d", got_cnt, NOUT); end
        for (int k = 0; k < NOUT; k++) begin
            n_cmp++;
            if (got_w[k] !== exp_word(k, 3)) begin n_bad++; $display("FAIL bp_re[%0d] got %h want %h", k, got_w[k], exp_word(k, 3)); end
        end
        n_cmp++; if (stall_err !== 0) begin n_bad++; $display("FAIL bp_stall_stable got %0d changes want 0", stall_err); end
        n_cmp++; if (rdy_err !== 0) begin n_bad++; $display("FAIL bp_ready_in_stall got %0d want 0", rdy_err); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL bp_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_sparse;
        run_slot(0, 1, -1, -1);
        n_cmp++; if (got_cnt !== NOUT) begin n_bad++; $display("FAIL sparse_count got %0d want %0d", got_cnt, NOUT); end
        for (int k = 0; k < NOUT; k++) begin
            n_cmp++;
            if (got_w[k] !== exp_word(k, 3)) begin n_bad++; $display("FAIL sparse_re[%0d] got %h want %h", k, got_w[k], exp_word(k, 3)); end
        end
        n_cmp++;
        if (got_cyc[47] - got_cyc[36] !== 11) begin
            n_bad++; $display("FAIL sparse_pilot_burst got span %0d want 11", got_cyc[47] - got_cyc[36]);
        end
    endtask

    task automatic test_ignored_start;
        run_slot(0, 0, 40, -1);
        n_cmp++; if (got_cnt !== NOUT) begin n_bad++; $display("FAIL ign_count got %0d want %0d", got_cnt, NOUT); end
        for (int k = 0; k < NOUT; k++) begin
            n_cmp++;
            if (got_w[k] !== exp_word(k, 3)) begin n_bad++; $display("FAIL ign_re[%0d] got %h want %h", k, got_w[k], exp_word(k, 3)); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL ign_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid;
        int done_seen;
        run_slot(0, 0, -1, 50);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", valid); end
        n_cmp++; if ({re, sc, sym, pflag} !== 40'h0) begin n_bad++; $display("FAIL rstmid_outputs got %h want 0", {re, sc, sym, pflag}); end
        n_cmp++; if (data_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready got %b want 0", data_ready); end
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sdone) done_seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sdone) done_seen++;
        end
        n_cmp++; if (done_seen !== 0) begin n_bad++; $display("FAIL rstmid_no_done got %0d pulses want 0", done_seen); end
        run_slot(0, 0, -1, -1);
        n_cmp++; if (got_cnt !== NOUT) begin n_bad++; $display("FAIL rstmid_count got %0d want %0d", got_cnt, NOUT); end
        for (int k = 0; k < NOUT; k++) begin
            n_cmp++;
            if (got_w[k] !== exp_word(k, 3)) begin n_bad++; $display("FAIL rstmid_re[%0d] got %h want %h", k, got_w[k], exp_word(k, 3)); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL rstmid_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_pilot_sym0;
        int in_idx, cnt, rdy_bad, done;
        pilot1 = pilot_vec('h100);
        out_ready1 = 1'b1; dvalid1 = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        in_idx = 0; cnt = 0; rdy_bad = 0; done = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            data1 = data_val(in_idx);
            dvalid1 = (in_idx < 72);
            @(negedge clk);
            if (cyc < 12 && data_ready1) rdy_bad++;
            if (cyc == 12) begin
                n_cmp++; if (data_ready1 !== 1'b1) begin n_bad++; $display("FAIL ps0_ready_sym1 got %b want 1", data_ready1); end
            end
            if (valid1) begin
                if (cnt < NOUT) begin
                    n_cmp++;
                    if ({re1, sc1, sym1, pflag1} !== exp_word(cnt, 0)) begin
                        n_bad++; $display("FAIL ps0_re[%0d] got %h want %h", cnt, {re1, sc1, sym1, pflag1}, exp_word(cnt, 0));
                    end
                end
                cnt++;
            end
            if (dvalid1 && data_ready1) in_idx++;
            if (sdone1) done++;
            @(posedge clk); #1;
            if (done > 0) break;
        end
        n_cmp++; if (rdy_bad !== 0) begin n_bad++; $display("FAIL ps0_ready_pilot got %0d want 0", rdy_bad); end
        n_cmp++; if (cnt !== NOUT) begin n_bad++; $display("FAIL ps0_count got %0d want %0d", cnt, NOUT); end
        n_cmp++; if (done !== 1) begin n_bad++; $display("FAIL ps0_done got %0d want 1", done); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        start = 1'b0; dvalid = 1'b0; out_ready = 1'b1; data = '0; pilot = '0;
        start1 = 1'b0; dvalid1 = 1'b0; out_ready1 = 1'b1; data1 = '0; pilot1 = '0;
        test_reset;
        test_basic;
        test_backpressure;
        test_sparse;
        test_ignored_start;
        test_reset_mid;
        test_pilot_sym0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tx_pilot_mapper.md
Name: tx_pilot_mapper

Overview:
Transmit-side NPUSCH resource mapper for one single-tone-group slot. It takes a serial stream of 72 modulated data REs (6 data symbols × 12 subcarriers) and the 12-entry DMRS pilot vector. It emits 84 REs in subcarrier-major order per symbol, inserting the pilot symbol at position PILOT_SYM. It sits between the modulator/transform precoder and the IFFT input buffer, and produces the pilots that the receive-side channel estimator inverts.

Parameters:
DATA_WIDTH, 16, width of each I/Q component (Q4.12 two's complement)
N_SC, 12, subcarriers per symbol
N_SYM, 7, symbols per slot
PILOT_SYM, 3, symbol index (0..N_SYM-1) carrying DMRS

Ports:
i_clk_map  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  slot start pulse; sampled only in IDLE
i_pilot  in  [N_SC-1:0][2*DATA_WIDTH]  DMRS vector {re,im}; latched on accepted i_start
i_data_valid  in  1  data RE valid
i_data  in  2*DATA_WIDTH  data RE {re[31:16], im[15:0]}
o_data_ready  out  1  mapper accepts data RE this cycle
o_valid  out  1  output RE valid
i_out_ready  in  1  downstream accepts output RE
o_re  out  2*DATA_WIDTH  mapped RE {re,im}
o_sc_idx  out  4  subcarrier index of o_re (0..11)
o_sym_num  out  3  symbol index of o_re (0..6)
o_pilot_flag  out  1  o_re is a DMRS RE
o_slot_done  out  1  one-cycle pulse after last RE handshake

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE. o_valid, o_pilot_flag, o_slot_done=0. o_re=0, o_sc_idx=0, o_sym_num=0, o_data_ready=0. Pilot register cleared.
- Output stage is one register. load_en = !o_valid || i_out_ready. o_valid/o_re/indices stay stable while o_valid && !i_out_ready.
- FSM states:
  - IDLE: i_start=1 → latch i_pilot, sc=0, sym=0. Go to PILOT if PILOT_SYM==0, otherwise MAP.
  - MAP: o_data_ready = load_en. An input handshake (i_data_valid && o_data_ready) loads i_data into the output register with the current sc/sym and pilot_flag=0, then advances the counters.
  - PILOT: entered when sym==PILOT_SYM. Each cycle with load_en=1 loads pilot[sc] with pilot_flag=1, and o_data_ready=0 throughout. No input is consumed for the 12 pilot REs.
  - DRAIN: entered after the RE with sym=N_SYM-1, sc=N_SC-1 is loaded. Wait for its output handshake, then go to DONE.
  - DONE: o_slot_done=1 for exactly one cycle, then IDLE.
- Counters:
  - sc wraps 11→0 and increments sym.
  - After any load, if the next sym==PILOT_SYM go to PILOT; else stay in or return to MAP.
  - After the last load go to DRAIN.
- Latency: 1 cycle from input handshake (or pilot load) to o_valid.
- Throughput: one RE per cycle with i_out_ready held high. A full slot is 84 output cycles plus DONE.
- Width: o_re is a pass-through bit copy. No arithmetic, rounding or saturation.
- i_start outside IDLE is ignored. A new slot may be started in the cycle after DONE.
- i_data_valid in IDLE/PILOT/DRAIN/DONE is ignored. Data is not consumed because o_data_ready=0.
- Simultaneous output stall and input valid: o_data_ready=0 and no data is lost.
- Reset mid-slot: everything returns to reset values immediately. A partial slot is discarded and o_slot_done is not asserted.
- i_pilot changes after the i_start latch do not affect the current slot.

Decomposition:
- Package nb_tx_pkg holds:
  - typedef enum logic [2:0] {IDLE, MAP, PILOT, DRAIN, DONE} map_state_t
  - constants N_SC=12, N_SYM=7, PILOT_SYM=3
  - typedef logic signed [2*DATA_WIDTH-1:0] cplx_t
- One sub-module, map_ctrl_fsm, holds the state, sc/sym counters and the load/ready decode. The datapath mux and output register stay in the top level.

Test Plan:
- Basic slot: i_start with pilot[k]={k+0x100,k}; data REs 0..71 with {n,-n}; i_out_ready=1. Required: 84 outputs; sym 3 carries pilot[0..11] with o_pilot_flag=1; data RE n appears at sym=n/12 (+1 if ≥3), sc=n%12; o_slot_done pulses the cycle after the last handshake.
- Backpressure: i_out_ready toggles 1,0,0,1 repeatedly. Required: o_re/indices stable during the stall; o_data_ready=0 while stalled; the output sequence equals the basic test's; no RE dropped or duplicated.
- Sparse input: i_data_valid high one cycle in three. Required: same 84-RE order; the 12 pilot REs emit back-to-back at sym 3 without waiting for input.
- Ignored start/pilot change: pulse i_start and change i_pilot at RE 40. Required: slot continues unaffected; pilots equal the values latched at the original start.
- Reset mid-slot: assert i_rst_n=0 at RE 50. Required: o_valid=0 and outputs zero asynchronously; no o_slot_done. A following i_start produces a clean full slot from sym 0, sc 0.
- PILOT_SYM=0 variant: required first 12 outputs are pilot REs; o_data_ready=0 until sc wraps to sym 1.
